unidade_prox_pc: RTL and testbench

//  Registered next-PC unit for the MIPS datapath; the sequential, parametrised successor of the branch-target adder.

---
 rtl/mips_pkg.sv | 15 +
 rtl/pilha_retorno.sv | 61 ++++++
 rtl/unidade_prox_pc.sv | 95 +++++++++
 tb/tb_unidade_prox_pc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: next-PC select encodings and word geometry.
// Imported by the next-PC unit and its return-address stack.
package mips_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned INSTR_INC = 4;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } sel_e;

endpackage

// File: rtl/pilha_retorno.sv
// Circular return-address stack: push/pop with saturating count, sticky overflow on wrap,
// and push+pop replacing the top entry in place.
module pilha_retorno #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             overflow,
    output logic             pop_valid
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_top;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full;

    // ptr_q is the next free slot; the top entry sits one below it
    assign ptr_top   = ptr_q - PTR_W'(1);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(RAS_DEPTH));
    assign pop_valid = !empty;
    assign top       = empty ? '0 : mem_q[ptr_top];
    assign overflow  = overflow_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && pop && !empty) begin
            mem_q[ptr_top] <= push_data;
        end else if (push) begin
            // When full, slot ptr_q holds the oldest entry, so it is overwritten
            mem_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (full) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_q   <= ptr_top;
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/unidade_prox_pc.sv
// Registered next-PC unit: PC register, PC+4/branch/jump targets, next-PC select with stall,
// and a return-address stack that checks jr $ra predictions.
module unidade_prox_pc
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH        = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_addr,
    input  logic             link,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_overflow,
    output logic             ras_mispredict,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] jump_target;
    logic             mispredict_q;
    logic             mispredict_d;
    logic             misaligned_q;
    logic             do_push;
    logic             do_pop;
    logic             pop_valid;

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + WIDTH'(INSTR_INC);
    assign branch_target = pc_plus4 + (offset << 2);
    assign jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_SEQ:    next_pc = pc_plus4;
            SEL_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
            SEL_JUMP:   next_pc = jump_target;
            SEL_JR:     next_pc = jr_addr;
            default:    next_pc = pc_plus4;
        endcase
    end

    // A stalled cycle drops link/ret entirely rather than deferring them
    assign do_push = !stall && link;
    assign do_pop  = !stall && ret && (sel == SEL_JR);

    // Compare against the pre-update top, also when push and pop coincide
    assign mispredict_d = do_pop && (!pop_valid || (ras_top != jr_addr));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
            if (!stall) begin
                pc_q         <= next_pc;
                misaligned_q <= |next_pc[1:0];
            end
        end
    end

    assign ras_mispredict = mispredict_q;
    assign misaligned     = misaligned_q;

    pilha_retorno #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_pilha_retorno (
        .clock     (clock),
        .reset     (reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .pop_valid (pop_valid)
    );

endmodule

// File: tb/tb_unidade_prox_pc.sv
// Self-checking bench for unidade_prox_pc: directed scenarios plus random stimulus checked
// against a queue-based reference model.
module tb_unidade_prox_pc;

    localparam int unsigned  D  = 4;
    localparam logic [31:0]  RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  sel;
    logic        branch_taken;
    logic [31:0] offset;
    logic [25:0] jump_index;
    logic [31:0] jr_addr;
    logic        link;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_overflow;
    logic        ras_mispredict;
    logic        misaligned;

    unidade_prox_pc #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (D)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .sel            (sel),
        .branch_taken   (branch_taken),
        .offset         (offset),
        .jump_index     (jump_index),
        .jr_addr        (jr_addr),
        .link           (link),
        .ret            (ret),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .branch_target  (branch_target),
        .ras_top        (ras_top),
        .ras_empty      (ras_empty),
        .ras_overflow   (ras_overflow),
        .ras_mispredict (ras_mispredict),
        .misaligned     (misaligned)
    );

    always #5 clock = ~clock;

    // Reference model: architectural PC, flags and the RAS as a queue (newest at the back)
    logic [31:0] pc_m;
    logic        mis_m;
    logic        pred_m;
    logic        ovf_m;
    logic [31:0] q[$];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pc_m   = RV;
        mis_m  = 1'b0;
        pred_m = 1'b0;
        ovf_m  = 1'b0;
        q.delete();
    endtask

    task automatic check_state(input string tag);
        logic [31:0] top_m;
        top_m = (q.size() != 0) ? q[q.size()-1] : 32'h0;
        check_eq({tag, ".pc"}, pc, pc_m);
        check_eq({tag, ".pc_plus4"}, pc_plus4, pc_m + 32'd4);
        check_eq({tag, ".branch_target"}, branch_target, pc_m + 32'd4 + offset * 32'd4);
        check_eq({tag, ".ras_top"}, ras_top, top_m);
        check_eq({tag, ".ras_empty"}, ras_empty, q.size() == 0);
        check_eq({tag, ".ras_overflow"}, ras_overflow, ovf_m);
        check_eq({tag, ".ras_mispredict"}, ras_mispredict, pred_m);
        check_eq({tag, ".misaligned"}, misaligned, mis_m);
    endtask

    task automatic model_step(input logic st, input logic [1:0] s, input logic tk,
                              input logic [31:0] off, input logic [25:0] ji,
                              input logic [31:0] ja, input logic lk, input logic rt);
        logic [31:0] p4;
        logic [31:0] nxt;
        logic        popping;
        pred_m = 1'b0;
        if (!st) begin
            p4 = pc_m + 32'd4;
            case (s)
                2'd0:    nxt = p4;
                2'd1:    nxt = tk ? p4 + off * 32'd4 : p4;
                2'd2:    nxt = (p4 & 32'hF000_0000) | (32'(ji) * 32'd4);
                default: nxt = ja;
            endcase
            popping = rt && (s == 2'd3);
            if (lk && popping) begin
                if (q.size() == 0) begin
                    q.push_back(p4);
                    pred_m = 1'b1;
                end else begin
                    pred_m = (q[q.size()-1] != ja);
                    q[q.size()-1] = p4;
                end
            end else if (lk) begin
                q.push_back(p4);
                if (q.size() > D) begin
                    void'(q.pop_front());
                    ovf_m = 1'b1;
                end
            end else if (popping) begin
                if (q.size() == 0) begin
                    pred_m = 1'b1;
                end else begin
                    pred_m = (q[q.size()-1] != ja);
                    void'(q.pop_back());
                end
            end
            pc_m  = nxt;
            mis_m = (nxt % 4) != 0;
        end
    endtask

    // One clock: drive, check pre-edge, step model, check post-edge
    task automatic cycle(input logic st, input logic [1:0] s, input logic tk,
                         input logic [31:0] off, input logic [25:0] ji,
                         input logic [31:0] ja, input logic lk, input logic rt);
        stall        = st;
        sel          = s;
        branch_taken = tk;
        offset       = off;
        jump_index   = ji;
        jr_addr      = ja;
        link         = lk;
        ret          = rt;
        #1;
        check_state("pre");
        model_step(st, s, tk, off, ji, ja, lk, rt);
        @(posedge clock);
        #1;
        check_state("post");
    endtask

    task automatic go_jr(input logic [31:0] a);
        cycle(1'b0, 2'd3, 1'b0, 32'h0, 26'h0, a, 1'b0, 1'b0);
    endtask

    task automatic seq_link();
        cycle(1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic jr_ret(input logic [31:0] a);
        cycle(1'b0, 2'd3, 1'b0, 32'h0, 26'h0, a, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_pop [4];
        logic [31:0] ja;
        exp_pop = '{32'h14, 32'h10, 32'hC, 32'h8};

        reset = 1'b1;
        stall = 1'b0; sel = 2'd0; branch_taken = 1'b0; offset = '0;
        jump_index = '0; jr_addr = '0; link = 1'b0; ret = 1'b0;
        model_reset();
        #12;
        reset = 1'b0;
        check_eq("reset_pc", pc, 32'h0040_0000);
        check_eq("reset_empty", ras_empty, 1'b1);

        // Call/return: correct prediction, then a mispredicted return
        go_jr(32'h40);
        seq_link();
        check_eq("call_top", ras_top, 32'h44);
        jr_ret(32'h44);
        check_eq("ret_ok_pred", ras_mispredict, 1'b0);
        check_eq("ret_ok_empty", ras_empty, 1'b1);
        go_jr(32'h40);
        seq_link();
        jr_ret(32'h48);
        check_eq("ret_bad_pred", ras_mispredict, 1'b1);
        cycle(1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_eq("ret_bad_pulse", ras_mispredict, 1'b0);

        // Branch taken / not taken / stalled
        go_jr(32'h100);
        cycle(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        check_eq("br_taken", pc, 32'hFC);
        go_jr(32'h100);
        cycle(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        check_eq("br_not_taken", pc, 32'h104);
        cycle(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b1, 1'b0);
        check_eq("br_stall", pc, 32'h104);

        // Jump and misaligned JR
        go_jr(32'h1000_0000);
        cycle(1'b0, 2'd2, 1'b0, 32'h0, 26'h40, 32'h0, 1'b0, 1'b0);
        check_eq("jump", pc, 32'h1000_0100);
        go_jr(32'h202);
        check_eq("jr_pc", pc, 32'h202);
        check_eq("jr_misaligned", misaligned, 1'b1);

        // Overflow then drain
        go_jr(32'h0);
        for (int i = 0; i < 5; i++) seq_link();
        check_eq("ovf_flag", ras_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_top", ras_top, exp_pop[i]);
            jr_ret(exp_pop[i]);
            check_eq("ovf_pop_pred", ras_mispredict, 1'b0);
        end
        jr_ret(32'h0);
        check_eq("ovf_empty_pop", ras_mispredict, 1'b1);

        // PC wrap and simultaneous push+pop
        go_jr(32'hFFFF_FFFC);
        cycle(1'b0, 2'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_eq("wrap_pc", pc, 32'h0);
        seq_link();
        cycle(1'b0, 2'd3, 1'b0, 32'h0, 26'h0, 32'h4, 1'b1, 1'b1);
        check_eq("swap_top", ras_top, 32'h8);
        check_eq("swap_pred", ras_mispredict, 1'b0);
        jr_ret(32'h8);
        check_eq("swap_count", ras_empty, 1'b1);

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1 && q.size() != 0) ja = q[q.size()-1];
            else if ($urandom_range(0, 7) == 0) ja = $urandom;
            else ja = $urandom & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom),
                  32'($signed(16'($urandom))), 26'($urandom), ja,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset between edges, with state loaded
        for (int i = 0; i < 5; i++) seq_link();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_mid_pc", pc, 32'h0040_0000);
        check_eq("rst_mid_ovf", ras_overflow, 1'b0);
        check_eq("rst_mid_empty", ras_empty, 1'b1);
        check_eq("rst_mid_mis", misaligned, 1'b0);
        check_eq("rst_mid_pred", ras_mispredict, 1'b0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) seq_link();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
